mux_nto1_skid: RTL and testbench

- Parametrised successor to the fixed 4-input datapath mux.
- Selects one of NUM_IN equal-width inputs and registers the result behind a valid/ready handshake.
- A 2-entry skid buffer lets the block run at full throughput while `ready_i` is registered upstream.
- Used between pipeline stages (forwarding/writeback select) where the consumer can stall and the hazard unit can flush.

---
 rtl/mux_nto1_skid.sv | 95 +++++++++
 tb/tb_mux_nto1_skid.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_skid.sv
// mux_nto1_skid: NUM_IN-to-1 registered mux behind a valid/ready handshake.
// A 2-entry (output + skid) buffer keeps full throughput while ready_o is
// driven purely from a register, so upstream may register its ready path.
module mux_nto1_skid #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 4,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        select_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    flush_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    err_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;

    logic [WIDTH-1:0] mux_val;
    logic             mux_err;
    logic             accept;
    logic             pop;

    // The skid only fills when the output register is occupied, so an empty
    // skid means there is always room for one more beat.
    assign ready_o = !skid_valid;
    assign valid_o = out_valid;
    assign data_o  = out_data;
    assign err_o   = out_err;

    assign accept = valid_i && ready_o;
    assign pop    = out_valid && ready_i;

    // Select the addressed input; out-of-range selects yield DEFAULT_VAL and flag err.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        mux_val = DEFAULT_VAL;
        mux_err = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (select_i == SEL_W'(k)) begin
                mux_val = data_i[k*WIDTH +: WIDTH];
                mux_err = 1'b0;
            end
        end
    end

    // Output/skid register update: flush, then drain skid, then fill output, then fill skid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: non-blocking assignments so all registers update together at the edge.
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (flush_i) begin
            // A beat accepted in the same cycle is dropped along with held beats.
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (skid_valid) begin
            // ready_o is low here, so no new beat can arrive; only a drain can occur.
            if (pop) begin
                out_data   <= skid_data;
                out_err    <= skid_err;
                skid_valid <= 1'b0;
            end
        end else if (!out_valid || pop) begin
            out_data  <= mux_val;
            out_err   <= mux_err;
            out_valid <= accept;
        end else if (accept) begin
            // Output is stalled: park the new beat so ready_o can drop a cycle late.
            skid_data  <= mux_val;
            skid_err   <= mux_err;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_nto1_skid.sv
// Testbench for mux_nto1_skid: two instances (NUM_IN=4 full-range, NUM_IN=3
// with DEFAULT_VAL=0xDEAD) share stimulus and are checked against a beat queue.
module tb_mux_nto1_skid;

    logic         clk;
    logic         rst_i;
    logic [127:0] data_w;
    logic [1:0]   select_i;
    logic         valid_i;
    logic         flush_i;
    logic         ready_i;

    logic         ready4, valid4, err4;
    logic [31:0]  data4;
    logic         ready3, valid3, err3;
    logic [31:0]  data3;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mux_nto1_skid #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(32'h0)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_w), .select_i(select_i),
        .valid_i(valid_i), .ready_o(ready4), .flush_i(flush_i),
        .data_o(data4), .err_o(err4), .valid_o(valid4), .ready_i(ready_i)
    );

    mux_nto1_skid #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(32'hDEAD)) dut3 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_w[95:0]), .select_i(select_i),
        .valid_i(valid_i), .ready_o(ready3), .flush_i(flush_i),
        .data_o(data3), .err_o(err3), .valid_o(valid3), .ready_i(ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference: queue of accepted beats ----------------
    typedef struct {
        logic [31:0] d4;
        logic [31:0] d3;
        logic        e3;
    } beat_t;

    beat_t q[$];

    function automatic beat_t mk_beat(input logic [1:0] s);
        beat_t b;
        b.d4 = data_w[int'(s)*32 +: 32];
        b.d3 = (s < 2'd3) ? data_w[int'(s)*32 +: 32] : 32'hDEAD;
        b.e3 = (s == 2'd3);
        return b;
    endfunction

    // Capacity is two beats; flush and reset empty the queue.
    always @(posedge clk or negedge rst_i) begin
        bit acc;
        bit pp;
        if (!rst_i) begin
            q.delete();
        end else begin
            acc = valid_i && (q.size() < 2);
            pp  = (q.size() > 0) && ready_i;
            if (flush_i) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(mk_beat(select_i));
            end
        end
    end

    // ---------------- compare process ----------------
    logic        prev_stall;
    logic [31:0] prev_d4;
    initial prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst_i) begin
            prev_stall <= 1'b0;
        end else if (chk_en) begin
            check("ready_o_n4", {31'b0, ready4}, {31'b0, q.size() < 2});
            check("ready_o_n3", {31'b0, ready3}, {31'b0, q.size() < 2});
            check("valid_o_n4", {31'b0, valid4}, {31'b0, q.size() > 0});
            check("valid_o_n3", {31'b0, valid3}, {31'b0, q.size() > 0});
            if (q.size() > 0) begin
                check("data_o_n4", data4, q[0].d4);
                check("err_o_n4", {31'b0, err4}, 32'h0);
                check("data_o_n3", data3, q[0].d3);
                check("err_o_n3", {31'b0, err3}, {31'b0, q[0].e3});
            end
            if (prev_stall) check("stable_n4", data4, prev_d4);
            prev_stall <= valid4 && !ready_i && !flush_i;
            prev_d4    <= data4;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        data_w = {w3, w2, w1, w0};
    endtask

    logic [31:0] exp_seq [4];

    initial begin
        exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33; exp_seq[3] = 32'h44;
        rst_i    = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        flush_i  = 1'b0;
        select_i = 2'd0;
        set_words(32'h11, 32'h22, 32'h33, 32'h44);
        #12;
        check("rst_valid", {31'b0, valid4}, 32'h0);
        check("rst_ready", {31'b0, ready4}, 32'h1);
        check("rst_data", data4, 32'h0);
        check("rst_err3", {31'b0, err3}, 32'h0);
        step();
        rst_i  = 1'b1;
        chk_en = 1'b1;
        step();

        // Back-to-back selects 0..3 with ready_i high.
        valid_i  = 1'b1;
        select_i = 2'd0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("seq_data", data4, exp_seq[k]);
            check("seq_valid", {31'b0, valid4}, 32'h1);
            check("seq_ready", {31'b0, ready4}, 32'h1);
            if (k < 3) select_i = 2'(k + 1);
            else valid_i = 1'b0;
        end
        step();
        check("seq_drain", {31'b0, valid4}, 32'h0);

        // Out-of-range select on the 3-input instance.
        valid_i  = 1'b1;
        select_i = 2'd3;
        step();
        check("oor_data", data3, 32'hDEAD);
        check("oor_err", {31'b0, err3}, 32'h1);
        check("oor_err_full", {31'b0, err4}, 32'h0);
        select_i = 2'd1;
        step();
        check("inr_data", data3, 32'h22);
        check("inr_err", {31'b0, err3}, 32'h0);
        valid_i = 1'b0;
        step();

        // Stall: A out, B skid, C held upstream, then drain in order.
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        select_i = 2'd0;
        step();
        check("stall_a", data4, 32'h11);
        check("stall_rdy1", {31'b0, ready4}, 32'h1);
        select_i = 2'd1;
        step();
        check("stall_a_hold", data4, 32'h11);
        check("stall_full", {31'b0, ready4}, 32'h0);
        select_i = 2'd2;
        step();
        check("stall_a_hold2", data4, 32'h11);
        ready_i = 1'b1;
        step();
        check("drain_b", data4, 32'h22);
        step();
        check("drain_c", data4, 32'h33);
        valid_i = 1'b0;
        step();
        check("drain_empty", {31'b0, valid4}, 32'h0);

        // Flush with skid full; D must never appear.
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        select_i = 2'd0;
        step();
        select_i = 2'd1;
        step();
        check("pre_flush_full", {31'b0, ready4}, 32'h0);
        flush_i  = 1'b1;
        select_i = 2'd3;
        step();
        check("flush_valid", {31'b0, valid4}, 32'h0);
        check("flush_ready", {31'b0, ready4}, 32'h1);
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        check("flush_no_d", {31'b0, valid4}, 32'h0);

        // Asynchronous reset mid-operation, between clock edges.
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        select_i = 2'd2;
        step();
        step();
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_valid", {31'b0, valid4}, 32'h0);
        check("arst_data", data4, 32'h0);
        check("arst_ready", {31'b0, ready4}, 32'h1);
        step();
        rst_i    = 1'b1;
        ready_i  = 1'b1;
        select_i = 2'd1;
        step();
        check("post_rst_data", data4, 32'h22);
        check("post_rst_valid", {31'b0, valid4}, 32'h1);
        valid_i = 1'b0;
        step();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            valid_i  = ($urandom_range(0, 9) < 7);
            ready_i  = ($urandom_range(0, 9) < 6);
            flush_i  = ($urandom_range(0, 31) == 0);
            select_i = 2'($urandom_range(0, 3));
            set_words($urandom, $urandom, $urandom, $urandom);
            step();
        end
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        step();
        step();
        step();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
